temp_sampler: RTL and testbench
===============================

TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- raw_data, in, 12, signed sensor code, Q7.4.
- raw_valid, in, 1, raw_data valid.
- raw_ready, out, 1, block accepts raw_data; a sample transfers when raw_valid and raw_ready are both 1.
- avg_log2, in, 3, block-average length 2^avg_log2; values above 4 are treated as 4.
- timeout_cyc, in, 16, stale timeout in cycles; 0 disables the timeout.
- dt_mode, in, 1, internal-dT mode enable; its rising edge requests an estimator restart.
- T_cur, out, 8, signed averaged temperature, Q7.0, held between updates.
- t_valid, out, 1, 1-cycle strobe: T_cur updated this cycle.
- init, out, 1, 1-cycle restart pulse for the downstream dT estimator.
- stale, out, 1, no fresh temperature available.

Function
REQ-002 The FSM SHALL have three states:
- WAIT: no block in progress.
- ACC: accumulating a block.
- EMIT: one-cycle rounding and saturation.
REQ-003 raw_ready SHALL be 1 in WAIT and ACC, and 0 in EMIT.
REQ-004 On an accepted sample in WAIT, the block SHALL:
- latch the effective avg_log2 (clamped to 4) for the whole block;
- load the accumulator with the sign-extended sample;
- load the block count with 1;
- go to ACC, or to EMIT directly if the latched length is 1.
REQ-005 In ACC each accepted sample SHALL be added into a 17-bit signed accumulator; the block count SHALL increment.
REQ-006 When the accepted sample completes 2^avg_log2 samples (the completion cycle), the FSM SHALL enter EMIT on the next edge.
REQ-007 In EMIT, with s = avg_log2 + 4, the result SHALL be (acc + 2^(s-1)) >>> s (arithmetic shift; ties round toward +inf).
REQ-008 The EMIT result SHALL saturate to [-128, 127].
REQ-009 On the edge leaving EMIT the block SHALL:
- register T_cur;
- pulse t_valid for 1 cycle;
- clear stale;
- return to WAIT.
REQ-010 Latency SHALL be 2 cycles: last sample accepted in cycle n -> EMIT in n+1 -> T_cur/t_valid visible in n+2.
REQ-011 Maximum throughput SHALL be one block per 2^avg_log2 + 1 cycles.
REQ-012 A pending-init flag SHALL be set by each of:
- reset release;
- a dt_mode rising edge (dt_mode and not its 1-cycle delayed copy);
- a stale timeout.
REQ-013 init SHALL be asserted in the same cycle as the t_valid that follows a pending-init set; the flag SHALL then clear.
REQ-014 A dt_mode rising edge in the EMIT cycle SHALL apply to that emit.
REQ-015 init SHALL never be asserted without t_valid, so a downstream estimator sees the new T_cur and the restart together.
REQ-016 An idle counter SHALL count cycles since the last accepted sample: it clears on accept and saturates at 0xFFFF.
REQ-017 When timeout_cyc != 0 and the idle counter reaches timeout_cyc, the block SHALL:
- set stale;
- discard any partial accumulation;
- go to WAIT;
- set pending-init.
REQ-018 stale SHALL stay 1 until the next t_valid.
REQ-019 A timeout and an accept in the same cycle SHALL resolve to the accept (no timeout).
REQ-020 Changes to avg_log2 mid-block SHALL take effect only at the next block start.
REQ-021 T_cur SHALL hold its last value while stale, and after a timeout.

Reset
REQ-022 On rst_n low, asynchronously, the block SHALL set:
- FSM to WAIT;
- accumulator, block count and idle counter to 0;
- T_cur = 0, t_valid = 0, init = 0;
- stale = 1;
- pending-init = 1;
- dt_mode delayed copy = 0.
REQ-023 raw_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-024 A reset mid-block SHALL discard the partial accumulation, with no t_valid.

Structure
REQ-025 The shared project package SHALL hold:
- RAW_W = 12, RAW_FRAC = 4, AVG_LOG2_MAX = 4, ACC_W = 17;
- the FSM state enum (WAIT, ACC, EMIT).
REQ-026 Round-and-saturate SHALL be one combinational sub-module, q_round_sat.
- Inputs: ACC_W-bit signed value and a shift amount.
- Output: Q7.0 saturated value.
- It is reusable by other Q-format stages.

Verification
REQ-027 avg_log2=0, raw=0x1F8 (31.5) -> T_cur=32, t_valid 2 cycles after accept, init=1 (first after reset), stale falls to 0.
REQ-028 avg_log2=0, raw=0xFF8 (-0.5) -> T_cur=0; raw=0x7FF (127.9375) -> T_cur=127 (saturated); raw=0x800 -> T_cur=-128.
REQ-029 avg_log2=2, raw 0x010, 0x020, 0x030, 0x040 back-to-back -> T_cur=3 (2.5 rounds up), raw_ready=0 exactly in the EMIT cycle, init=0.
REQ-030 timeout_cyc=100, avg_log2=1, one sample then none for 100 cycles -> stale=1 at idle count 100, no t_valid; next block -> t_valid with init=1.
REQ-031 dt_mode 0->1 in the EMIT cycle -> init=1 on that t_valid; dt_mode held high -> next emit init=0.
REQ-032 rst_n asserted during ACC after 2 of 4 samples -> all outputs at reset values; next block emits a clean 4-sample average with init=1.

Source files
------------

// File: rtl/temp_sampler_pkg.sv
// rtl/temp_sampler_pkg.sv - shared widths and FSM state type for the temperature sampler
package temp_sampler_pkg;

  localparam int RAW_W        = 12;
  localparam int RAW_FRAC     = 4;
  localparam int AVG_LOG2_MAX = 4;
  localparam int ACC_W        = 17;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/q_round_sat.sv
// rtl/q_round_sat.sv - round-half-up arithmetic shift and saturation to signed Q7.0
module q_round_sat
  import temp_sampler_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic        [3:0]       shift,
  output logic signed [7:0]       q_out
);

  // One extra bit of headroom so the rounding bias can never wrap the sum.
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  // Add half an LSB of the result, shift arithmetically, then clip to 8 bits.
  always_comb begin
    bias = '0;
    if (shift != 4'd0) begin
      bias = (ACC_W + 1)'(1) << (shift - 4'd1);
    end
    sum     = {acc_in[ACC_W-1], acc_in} + bias;
    shifted = sum >>> shift;
    if ((&shifted[ACC_W:7]) || (~|shifted[ACC_W:7])) begin
      q_out = shifted[7:0];
    end else if (shifted[ACC_W]) begin
      q_out = 8'sh80;
    end else begin
      q_out = 8'sh7F;
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// rtl/temp_sampler.sv - block-averaging temperature sampler with stale timeout and estimator restart
module temp_sampler
  import temp_sampler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAW_W-1:0]  raw_data,
  input  logic              raw_valid,
  output logic              raw_ready,
  input  logic [2:0]        avg_log2,
  input  logic [15:0]       timeout_cyc,
  input  logic              dt_mode,
  output logic signed [7:0] T_cur,
  output logic              t_valid,
  output logic              init,
  output logic              stale
);

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic [4:0]              blk_cnt;
  logic [2:0]              len_log2;
  logic [15:0]             idle_cnt;
  logic                    pend_init;
  logic                    dt_d;
  logic                    accept;
  logic                    timeout;
  logic                    dt_rise;
  logic [2:0]              avg_eff;
  logic signed [ACC_W-1:0] raw_ext;
  logic signed [7:0]       q_val;

  assign avg_eff = (avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : avg_log2;
  assign raw_ext = {{(ACC_W - RAW_W){raw_data[RAW_W-1]}}, raw_data};
  assign dt_rise = dt_mode & ~dt_d;

  // Handshake, timeout detection and next-state selection; an accept beats a timeout.
  always_comb begin
    state_next = state;
    raw_ready  = rst_n && (state != EMIT);
    accept     = raw_valid && raw_ready;
    timeout    = (timeout_cyc != 16'd0) && (idle_cnt == timeout_cyc) && !accept;
    case (state)
      WAIT: begin
        if (accept) begin
          state_next = (avg_eff == 3'd0) ? EMIT : ACC;
        end
      end
      ACC: begin
        if (accept && ((blk_cnt + 5'd1) == (5'd1 << len_log2))) begin
          state_next = EMIT;
        end
      end
      EMIT:    state_next = WAIT;
      default: state_next = WAIT;
    endcase
    if (timeout) begin
      state_next = WAIT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Accumulation, idle tracking, restart bookkeeping and result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      blk_cnt   <= '0;
      len_log2  <= '0;
      idle_cnt  <= '0;
      T_cur     <= '0;
      t_valid   <= 1'b0;
      init      <= 1'b0;
      stale     <= 1'b1;
      pend_init <= 1'b1;
      dt_d      <= 1'b0;
    end else begin
      t_valid <= 1'b0;
      init    <= 1'b0;
      dt_d    <= dt_mode;

      if (accept) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 16'hFFFF) begin
        idle_cnt <= idle_cnt + 16'd1;
      end

      // A rise during EMIT is folded straight into that emit below.
      if (dt_rise && (state != EMIT)) begin
        pend_init <= 1'b1;
      end

      if (timeout) begin
        stale     <= 1'b1;
        pend_init <= 1'b1;
        acc       <= '0;
        blk_cnt   <= '0;
      end else if (accept) begin
        if (state == WAIT) begin
          len_log2 <= avg_eff;
          acc      <= raw_ext;
          blk_cnt  <= 5'd1;
        end else begin
          acc     <= acc + raw_ext;
          blk_cnt <= blk_cnt + 5'd1;
        end
      end

      if (state == EMIT) begin
        T_cur     <= q_val;
        t_valid   <= 1'b1;
        stale     <= 1'b0;
        init      <= pend_init | dt_rise;
        pend_init <= 1'b0;
      end
    end
  end

  q_round_sat u_round (
    .acc_in (acc),
    .shift  ({1'b0, len_log2} + 4'(RAW_FRAC)),
    .q_out  (q_val)
  );

endmodule

// File: tb/tb_temp_sampler.sv
// tb/tb_temp_sampler.sv - scoreboard bench for temp_sampler
module tb_temp_sampler;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [11:0]       raw_data;
  logic              raw_valid;
  logic              raw_ready;
  logic [2:0]        avg_log2;
  logic [15:0]       timeout_cyc;
  logic              dt_mode;
  logic signed [7:0] T_cur;
  logic              t_valid;
  logic              init;
  logic              stale;

  typedef struct {
    int t;
    int init;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_t   = 0;

  temp_sampler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_data    (raw_data),
    .raw_valid   (raw_valid),
    .raw_ready   (raw_ready),
    .avg_log2    (avg_log2),
    .timeout_cyc (timeout_cyc),
    .dt_mode     (dt_mode),
    .T_cur       (T_cur),
    .t_valid     (t_valid),
    .init        (init),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: mean of the block, rounded half toward +inf, clipped to 8-bit signed.
  function automatic int model(input int sum, input int ke);
    real v;
    int  r;
    v = real'(sum) / (16.0 * real'(1 << ke));
    r = int'($floor(v + 0.5));
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic void expect_push(input int t, input int i);
    exp_t e;
    e.t    = t;
    e.init = i;
    sb.push_back(e);
    last_t = t;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (init && !t_valid) check("init_without_t_valid", 1, 0);
      if (t_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_t_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("t_cur", int'(T_cur), e.t);
          check("init", int'(init), e.init);
          check("stale_after_emit", int'(stale), 0);
        end
      end
    end
  end

  // Called mid-cycle; returns mid-cycle after the accepting edge with raw_valid still high.
  task automatic push_sample(input logic [11:0] d);
    int n;
    n = 0;
    raw_data  = d;
    raw_valid = 1'b1;
    while (!raw_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!raw_ready) check("ready_bound", 0, 1);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic run_block(input int k, input logic [11:0] d[16], input int exp_init);
    int ke;
    int n;
    int sum;
    ke  = (k > 4) ? 4 : k;
    n   = 1 << ke;
    sum = 0;
    for (int i = 0; i < n; i++) sum += int'($signed(d[i]));
    avg_log2 = 3'(k);
    expect_push(model(sum, ke), exp_init);
    for (int i = 0; i < n; i++) push_sample(d[i]);
    raw_valid = 1'b0;
    check("ready_in_emit", int'(raw_ready), 0);
    check("t_valid_in_emit", int'(t_valid), 0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d[16];

    rst_n       = 1'b0;
    raw_data    = '0;
    raw_valid   = 1'b0;
    avg_log2    = '0;
    timeout_cyc = '0;
    dt_mode     = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", int'(raw_ready), 0);
    check("rst_t_cur", int'(T_cur), 0);
    check("rst_t_valid", int'(t_valid), 0);
    check("rst_init", int'(init), 0);
    check("rst_stale", int'(stale), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(raw_ready), 1);

    // Single sample with explicit latency checks; first emit carries the restart.
    avg_log2 = 3'd0;
    expect_push(32, 1);
    push_sample(12'h1F8);
    raw_valid = 1'b0;
    check("lat_ready_emit", int'(raw_ready), 0);
    check("lat_t_valid_n1", int'(t_valid), 0);
    check("lat_stale_n1", int'(stale), 1);
    @(negedge clk);
    check("lat_t_valid_n2", int'(t_valid), 1);
    drain();

    // Rounding and saturation corners.
    d[0] = 12'hFF8; run_block(0, d, 0);
    d[0] = 12'h7FF; run_block(0, d, 0);
    d[0] = 12'h800; run_block(0, d, 0);

    // Four-sample block, 2.5 rounds up to 3.
    d[0] = 12'h010; d[1] = 12'h020; d[2] = 12'h030; d[3] = 12'h040;
    run_block(2, d, 0);

    // avg_log2 above 4 behaves as 16-sample blocks.
    for (int i = 0; i < 16; i++) d[i] = 12'($urandom_range(0, 4095));
    run_block(7, d, 0);

    // Changing avg_log2 mid-block does not alter the current block.
    avg_log2 = 3'd1;
    expect_push(model(int'($signed(12'h123)) + int'($signed(12'hE10)), 1), 0);
    push_sample(12'h123);
    avg_log2 = 3'd3;
    push_sample(12'hE10);
    raw_valid = 1'b0;
    check("midblk_ready_emit", int'(raw_ready), 0);
    drain();

    // Stale timeout after a lone sample of a 2-sample block.
    timeout_cyc = 16'd100;
    avg_log2    = 3'd1;
    push_sample(12'h155);
    raw_valid = 1'b0;
    repeat (99) @(negedge clk);
    check("stale_before_timeout", int'(stale), 0);
    repeat (3) @(negedge clk);
    check("stale_after_timeout", int'(stale), 1);
    check("t_cur_held", int'(T_cur), last_t);
    d[0] = 12'h0A0; d[1] = 12'h0B0;
    run_block(1, d, 1);
    timeout_cyc = 16'd0;

    // dt_mode rising in the EMIT cycle applies to that emit only.
    avg_log2 = 3'd0;
    expect_push(model(int'($signed(12'hF31)), 0), 1);
    push_sample(12'hF31);
    raw_valid = 1'b0;
    dt_mode   = 1'b1;
    drain();
    d[0] = 12'h222;
    run_block(0, d, 0);
    dt_mode = 1'b0;

    // Reset in the middle of a 4-sample block.
    avg_log2 = 3'd2;
    push_sample(12'h300);
    push_sample(12'h310);
    raw_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_ready", int'(raw_ready), 0);
    check("midrst_t_cur", int'(T_cur), 0);
    check("midrst_t_valid", int'(t_valid), 0);
    check("midrst_init", int'(init), 0);
    check("midrst_stale", int'(stale), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d[0] = 12'h100; d[1] = 12'h110; d[2] = 12'h120; d[3] = 12'h131;
    run_block(2, d, 1);

    // A few random blocks of random length.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) d[i] = 12'($urandom_range(0, 4095));
      run_block(int'($urandom_range(0, 5)), d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
